mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the multicycle MIPS core, sitting beside the ALU in the execute stage. It implements mult, multu, div and divu, holding results in architectural HI/LO registers. Hazard and control logic use its start/busy/done handshake to hold the main state machine in execute until the result is ready. It also provides mthi/mtlo writes and continuous HI/LO read-out for mfhi/mflo.

---
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 tb/tb_mul_div_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Multiply is radix-2 shift-add, divide is restoring on magnitudes, both with a fixed 34-cycle latency.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opA_q, opA_d;
    logic [31:0] opB_q, opB_d;
    logic [63:0] acc_q, acc_d;
    logic        isDiv_q, isDiv_d;
    logic        negQ_q, negQ_d;
    logic        negR_q, negR_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signedOp;
    logic        divZero;
    logic        latchRaw;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [32:0] mulSum;
    logic [32:0] divTrial;
    logic [32:0] divDiff;
    logic        divGe;
    logic [31:0] remNext;
    logic [63:0] prodNeg;
    logic [31:0] quoNeg;
    logic [31:0] remNeg;

    // Divide by zero runs the unsigned algorithm on the raw operands, which naturally
    // yields quotient all-ones and remainder equal to the original dividend.
    always_comb begin
        signedOp = ~op[0];
        divZero  = op[1] & (srcb == 32'd0);
        latchRaw = ~signedOp | divZero;
        absA     = srca[31] ? (~srca + 32'd1) : srca;
        absB     = srcb[31] ? (~srcb + 32'd1) : srcb;
        mulSum   = {1'b0, acc_q[63:32]} + (opB_q[0] ? {1'b0, opA_q} : 33'd0);
        divTrial = {acc_q[63:32], opA_q[31]};
        divDiff  = divTrial - {1'b0, opB_q};
        divGe    = divTrial >= {1'b0, opB_q};
        remNext  = divGe ? divDiff[31:0] : divTrial[31:0];
        prodNeg  = ~acc_q + 64'd1;
        quoNeg   = ~acc_q[31:0] + 32'd1;
        remNeg   = ~acc_q[63:32] + 32'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        acc_d   = acc_q;
        isDiv_d = isDiv_q;
        negQ_d  = negQ_q;
        negR_d  = negR_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = 5'd0;
                    acc_d   = 64'd0;
                    isDiv_d = op[1];
                    negQ_d  = signedOp & ~divZero & (srca[31] ^ srcb[31]);
                    negR_d  = signedOp & ~divZero & op[1] & srca[31];
                    opA_d   = latchRaw ? srca : absA;
                    opB_d   = latchRaw ? srcb : absB;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            CALC: begin
                // Divide keeps the remainder in acc[63:32] and shifts quotient bits into acc[31:0].
                if (isDiv_q) begin
                    acc_d = {remNext, acc_q[30:0], divGe};
                    opA_d = {opA_q[30:0], 1'b0};
                end else begin
                    acc_d = {mulSum, acc_q[31:1]};
                    opB_d = {1'b0, opB_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = SIGN;
            end
            SIGN: begin
                if (isDiv_q) begin
                    lo_d = negQ_q ? quoNeg : acc_q[31:0];
                    hi_d = negR_q ? remNeg : acc_q[63:32];
                end else begin
                    {hi_d, lo_d} = negQ_q ? prodNeg : acc_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            opA_q   <= 32'd0;
            opB_q   <= 32'd0;
            acc_q   <= 64'd0;
            isDiv_q <= 1'b0;
            negQ_q  <= 1'b0;
            negR_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            acc_q   <= acc_d;
            isDiv_q <= isDiv_d;
            negQ_q  <= negQ_d;
            negR_q  <= negR_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a table of directed vectors plus hand-written
// sequences for busy-time writes, back-to-back starts and mid-operation reset.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] curHi    = 32'd0;
    logic [31:0] curLo    = 32'd0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[12];

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // glitchMode: 1 = second start at cycle 5, 2 = mthi at cycle 5, 3 = lo_we together with start.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int glitchMode, input bit noWait,
                                 output int lat, output bit busyOk, output bit stableOk);
        if (!noWait) @(negedge clk);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        if (glitchMode == 3) begin
            lo_we = 1'b1;
            wdata = 32'hDEADBEEF;
        end
        @(posedge clk);
        lat = 1;
        #1;
        start = 1'b0;
        lo_we = 1'b0;
        op    = ~o;
        srca  = ~a;
        srcb  = ~b;
        busyOk   = 1'b1;
        stableOk = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            start = 1'b0;
            hi_we = 1'b0;
            if (done) break;
            if (!busy) busyOk = 1'b0;
            if (hi !== curHi || lo !== curLo) stableOk = 1'b0;
            if (lat == 5 && glitchMode == 1) begin
                start = 1'b1;
                op    = 2'b01;
                srca  = 32'h00001111;
                srcb  = 32'h00002222;
            end
            if (lat == 5 && glitchMode == 2) begin
                hi_we = 1'b1;
                wdata = 32'hA5A5A5A5;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic runCase(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                           input int glitchMode, input bit noWait);
        int lat;
        bit busyOk;
        bit stableOk;
        applyStimulus(o, a, b, glitchMode, noWait, lat, busyOk, stableOk);
        checkOutput({name, " latency"}, 32'(lat), 32'd34);
        checkOutput({name, " busy"}, {31'd0, busyOk}, 32'd1);
        checkOutput({name, " hilo stable"}, {31'd0, stableOk}, 32'd1);
        checkOutput({name, " hi"}, hi, expHi);
        checkOutput({name, " lo"}, lo, expLo);
        curHi = expHi;
        curLo = expLo;
    endtask

    task automatic idleWrite(input bit wh, input bit wl, input logic [31:0] d);
        @(negedge clk);
        hi_we = wh;
        lo_we = wl;
        wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (wh) curHi = d;
        if (wl) curLo = d;
        @(negedge clk);
        checkOutput("mthi/mtlo hi", hi, curHi);
        checkOutput("mthi/mtlo lo", lo, curLo);
    endtask

    initial begin
        int  seenDone;
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[7]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[8]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[9]  = '{2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[10] = '{2'b00, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[11] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srca  = 32'd0;
        srcb  = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);

        idleWrite(1'b1, 1'b0, 32'hCAFEF00D);
        idleWrite(1'b0, 1'b1, 32'h0BADF00D);
        idleWrite(1'b1, 1'b1, 32'h13579BDF);

        for (int i = 0; i < 12; i++) begin
            runCase($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].expHi, vecs[i].expLo, 0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d done single pulse", i), {31'd0, done}, 32'd0);
        end

        runCase("second start ignored", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1, 1'b0);
        runCase("mthi while busy", 2'b01, 32'd3, 32'd3, 32'd0, 32'd9, 2, 1'b0);
        runCase("start with lo_we", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 3, 1'b0);

        runCase("b2b first", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 0, 1'b0);
        runCase("b2b second", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 0, 1'b1);

        // Abort a mult at cycle 10 and confirm no done pulse ever follows.
        @(negedge clk);
        op    = 2'b00;
        srca  = 32'hFFFFFFFD;
        srcb  = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        seenDone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seenDone++;
        end
        checkOutput("abort no done", 32'(seenDone), 32'd0);
        curHi = 32'd0;
        curLo = 32'd0;
        runCase("after abort", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
